// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter/sequencer: CPU (C) and loader (L) share one memory port.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed priority (C wins).
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_done,
  output logic          cpu_stall,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic [DW-1:0] ldr_rdata,
  output logic          ldr_done,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  // Handshake: a requester raises *_req with we/addr/wdata stable and holds it until
  // *_done; in the cycle after *_done it drops req or presents a new request. A req
  // still high during the done cycle is not sampled again.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, next_state;
  logic   win_l;     // winner of the access in flight: 0 = C, 1 = L
  logic   grant_l;   // arbitration result while IDLE
  logic   any_req;
  logic   start;
  logic   finish;

  assign any_req = cpu_req | ldr_req;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last_l;      // port served most recently: 0 = C, 1 = L

  assign grant_l = ldr_req & (~cpu_req | ~last_l);

  always_ff @(posedge clock) begin
    if (reset) begin
      last_l <= 1'b0;
    end else if (start) begin
      last_l <= grant_l;
    end
  end
`else
  assign grant_l = ldr_req & ~cpu_req;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = ACCESS;
      ACCESS:  next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    start     = 1'b0;
    finish    = 1'b0;
    busy      = 1'b0;
    dbg_state = state;
    case (state)
      IDLE:    start  = any_req;
      ACCESS:  begin finish = 1'b1; busy = 1'b1; end
      RESP:    busy   = 1'b1;
      default: busy   = 1'b0;
    endcase
  end

  // Memory-side request registers, completion pulses and read-data capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      win_l     <= 1'b0;
      cpu_done  <= 1'b0;
      ldr_done  <= 1'b0;
      cpu_rdata <= '0;
      ldr_rdata <= '0;
    end else begin
      cpu_done <= 1'b0;
      ldr_done <= 1'b0;
      if (start) begin
        win_l     <= grant_l;
        mem_we    <= grant_l ? ldr_we    : cpu_we;
        mem_addr  <= grant_l ? ldr_addr  : cpu_addr;
        mem_wdata <= grant_l ? ldr_wdata : cpu_wdata;
      end
      if (finish) begin
        mem_we <= 1'b0;
        if (win_l) begin
          ldr_done <= 1'b1;
          if (!mem_we) ldr_rdata <= mem_rdata;
        end else begin
          cpu_done <= 1'b1;
          if (!mem_we) cpu_rdata <= mem_rdata;
        end
      end
    end
  end

  assign cpu_stall = cpu_req & ~cpu_done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, corner-case sequences and
// randomized traffic checked against a transaction-level timing model.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        ldr_req = 1'b0, ldr_we = 1'b0;
  logic [31:0] ldr_addr = '0, ldr_wdata = '0;
  logic [31:0] cpu_rdata, ldr_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_done, cpu_stall, ldr_done, mem_we, busy;
  logic [1:0]  dbg_state;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  always #5 clock = ~clock;

  dmem_arbiter #(.AW(32), .DW(32)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata), .ldr_done(ldr_done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Data memory: combinational read, write on the rising edge.
  logic [31:0] mem [16];
  logic        mem_init = 1'b1;
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA5A5_0000 | i;
    end else if (mem_we) begin
      mem[mem_addr[5:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[5:2]];

  // Reference model: each granted access occupies the cycle g (memory access) and
  // g+1 (done pulse); a new grant is possible only from cycle g+2 on.
  int          cyc = 0;
  int          g = -10;
  int          win = 0;
  int          last = 0;
  logic        m_we = 1'b0;
  logic [31:0] m_addr = '0, m_wd = '0;
  logic [31:0] m_rd [2];
  logic [31:0] exp_mem [16];

  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) exp_mem[i] = 32'hA5A5_0000 | i;
    end else if (cyc == g && m_we) begin
      exp_mem[m_addr[5:2]] = m_wd;
    end
    if (reset) begin
      g = -10; m_we = 1'b0; m_addr = '0; m_wd = '0;
      m_rd[0] = '0; m_rd[1] = '0; last = 0;
    end else begin
      if (cyc == g && !m_we) m_rd[win] = exp_mem[m_addr[5:2]];
      if (cyc > g + 1 && (cpu_req || ldr_req)) begin
        if (cpu_req && ldr_req) win = RR ? 1 - last : 0;
        else                    win = cpu_req ? 0 : 1;
        last = win;
        g = cyc + 1;
        if (win == 0) begin m_we = cpu_we; m_addr = cpu_addr; m_wd = cpu_wdata; end
        else          begin m_we = ldr_we; m_addr = ldr_addr; m_wd = ldr_wdata; end
      end
    end
    cyc++;
  end

  function automatic logic e_cdone();
    return (cyc == g + 1) && (win == 0);
  endfunction
  function automatic logic e_ldone();
    return (cyc == g + 1) && (win == 1);
  endfunction

  // Scoreboard counters
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
  endtask

  task automatic check_model();
    chk("mem_we",    {31'b0, mem_we},    {31'b0, (cyc == g) && m_we});
    chk("mem_addr",  mem_addr,           m_addr);
    chk("mem_wdata", mem_wdata,          m_wd);
    chk("busy",      {31'b0, busy},      {31'b0, (cyc == g) || (cyc == g + 1)});
    chk("cpu_done",  {31'b0, cpu_done},  {31'b0, e_cdone()});
    chk("ldr_done",  {31'b0, ldr_done},  {31'b0, e_ldone()});
    chk("cpu_rdata", cpu_rdata,          m_rd[0]);
    chk("ldr_rdata", ldr_rdata,          m_rd[1]);
    chk("cpu_stall", {31'b0, cpu_stall}, {31'b0, cpu_req & ~e_cdone()});
  endtask

  // Requester agents: hold a request until its done, then drop it or issue the next.
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
  } req_t;

  req_t q_c[$], q_l[$];
  logic pend_c = 1'b0, pend_l = 1'b0, seen_c = 1'b0, seen_l = 1'b0;

  task automatic drive_agents();
    req_t r;
    if (pend_c && seen_c) begin pend_c = 1'b0; cpu_req = 1'b0; end
    if (pend_l && seen_l) begin pend_l = 1'b0; ldr_req = 1'b0; end
    if (!pend_c && q_c.size() > 0) begin
      r = q_c.pop_front();
      cpu_req = 1'b1; cpu_we = r.we; cpu_addr = r.addr; cpu_wdata = r.wd; pend_c = 1'b1;
    end
    if (!pend_l && q_l.size() > 0) begin
      r = q_l.pop_front();
      ldr_req = 1'b1; ldr_we = r.we; ldr_addr = r.addr; ldr_wdata = r.wd; pend_l = 1'b1;
    end
    seen_c = 1'b0;
    seen_l = 1'b0;
  endtask

  int order_q[$];
  int t_cd, t_ld, t_lw, stall_n, busy_n;

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check_model();
      if (cpu_done === 1'b1) begin order_q.push_back(0); if (t_cd < 0) t_cd = cyc; end
      if (ldr_done === 1'b1) begin order_q.push_back(1); if (t_ld < 0) t_ld = cyc; end
      if (mem_we === 1'b1 && mem_addr == 32'h24 && t_lw < 0) t_lw = cyc;
      if (cpu_stall === 1'b1) stall_n++;
      if (busy === 1'b1) busy_n++;
      seen_c = e_cdone();
      seen_l = e_ldone();
      @(posedge clock);
      #1;
      drive_agents();
    end
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    run(1);
    reset = 1'b0;
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.we   = 1'($urandom_range(0, 1));
    r.addr = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
    r.wd   = $urandom;
    return r;
  endfunction

  typedef struct {
    logic        creq, cwe;
    logic [31:0] caddr, cwd;
    logic        lreq, lwe;
    logic [31:0] laddr, lwd;
    logic        e_we;
    logic [31:0] e_addr, e_wd;
    logic        e_cd, e_ld, e_busy, e_stall;
    logic [31:0] e_crd, e_lrd;
  } vec_t;

  localparam logic [31:0] D = 32'hDEAD_BEEF;
  localparam logic [31:0] P = 32'h1234_5678;

  vec_t tab [14];
  int   k;
  int   exp_order [6];

  initial begin
    // Each row: inputs during that cycle, outputs expected in the same cycle.
    tab[0]  = '{0,0,0,0,     0,0,0,0,     0,0,0,     0,0,0,0, 0,0};
    tab[1]  = '{1,1,'h10,D,  0,0,0,0,     0,0,0,     0,0,0,1, 0,0};
    tab[2]  = '{1,1,'h10,D,  0,0,0,0,     1,'h10,D,  0,0,1,1, 0,0};
    tab[3]  = '{1,1,'h10,D,  0,0,0,0,     0,'h10,D,  1,0,1,0, 0,0};
    tab[4]  = '{1,0,'h10,0,  0,0,0,0,     0,'h10,D,  0,0,0,1, 0,0};
    tab[5]  = '{1,0,'h10,0,  0,0,0,0,     0,'h10,0,  0,0,1,1, 0,0};
    tab[6]  = '{1,0,'h10,0,  0,0,0,0,     0,'h10,0,  1,0,1,0, D,0};
    tab[7]  = '{0,0,0,0,     1,1,'h30,P,  0,'h10,0,  0,0,0,0, D,0};
    tab[8]  = '{0,0,0,0,     1,1,'h30,P,  1,'h30,P,  0,0,1,0, D,0};
    tab[9]  = '{0,0,0,0,     1,1,'h30,P,  0,'h30,P,  0,1,1,0, D,0};
    tab[10] = '{0,0,0,0,     1,0,'h30,0,  0,'h30,P,  0,0,0,0, D,0};
    tab[11] = '{0,0,0,0,     1,0,'h30,0,  0,'h30,0,  0,0,1,0, D,0};
    tab[12] = '{0,0,0,0,     1,0,'h30,0,  0,'h30,0,  0,1,1,0, D,P};
    tab[13] = '{0,0,0,0,     0,0,0,0,     0,'h30,0,  0,0,0,0, D,P};

    t_cd = -1; t_ld = -1; t_lw = -1; stall_n = 0; busy_n = 0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    mem_init = 1'b0;

    for (int r = 0; r < 14; r++) begin
      cpu_req = tab[r].creq; cpu_we = tab[r].cwe; cpu_addr = tab[r].caddr; cpu_wdata = tab[r].cwd;
      ldr_req = tab[r].lreq; ldr_we = tab[r].lwe; ldr_addr = tab[r].laddr; ldr_wdata = tab[r].lwd;
      @(negedge clock);
      chk($sformatf("tab%0d_mem_we", r),    {31'b0, mem_we},    {31'b0, tab[r].e_we});
      chk($sformatf("tab%0d_mem_addr", r),  mem_addr,           tab[r].e_addr);
      chk($sformatf("tab%0d_mem_wdata", r), mem_wdata,          tab[r].e_wd);
      chk($sformatf("tab%0d_cpu_done", r),  {31'b0, cpu_done},  {31'b0, tab[r].e_cd});
      chk($sformatf("tab%0d_ldr_done", r),  {31'b0, ldr_done},  {31'b0, tab[r].e_ld});
      chk($sformatf("tab%0d_busy", r),      {31'b0, busy},      {31'b0, tab[r].e_busy});
      chk($sformatf("tab%0d_cpu_stall", r), {31'b0, cpu_stall}, {31'b0, tab[r].e_stall});
      chk($sformatf("tab%0d_cpu_rdata", r), cpu_rdata,          tab[r].e_crd);
      chk($sformatf("tab%0d_ldr_rdata", r), ldr_rdata,          tab[r].e_lrd);
      @(posedge clock);
      #1;
    end

    // Collision: C loads 0x20 while L stores 0x55 to 0x24 in the same cycle.
    reset_pulse();
    q_c.push_back('{1'b0, 32'h20, 32'h0});
    q_l.push_back('{1'b1, 32'h24, 32'h55});
    drive_agents();
    k = cyc; t_cd = -1; t_ld = -1; t_lw = -1;
    run(10);
    chk("coll_cpu_done_cycle", t_cd - k, RR ? 5 : 2);
    chk("coll_ldr_we_cycle",   t_lw - k, RR ? 1 : 4);
    chk("coll_ldr_done_cycle", t_ld - k, RR ? 2 : 5);
    chk("coll_cpu_rdata",      cpu_rdata, 32'hA5A5_0008);

    // Three back-to-back collisions: record the order of completions.
    reset_pulse();
    for (int i = 0; i < 3; i++) begin
      q_c.push_back('{1'b0, 32'(4 * i), 32'h0});
      q_l.push_back('{1'b0, 32'(4 * (13 + i)), 32'h0});
    end
    drive_agents();
    order_q.delete();
    run(24);
    if (RR) exp_order = '{1, 0, 1, 0, 1, 0};
    else    exp_order = '{0, 0, 0, 1, 1, 1};
    chk("order_count", order_q.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("order%0d", i), (i < order_q.size()) ? order_q[i] : -1, exp_order[i]);

    // Stall: C load raised one cycle after an L access was sampled waits 4 cycles.
    q_l.push_back('{1'b0, 32'hC, 32'h0});
    drive_agents();
    run(1);
    q_c.push_back('{1'b0, 32'hC, 32'h0});
    drive_agents();
    stall_n = 0;
    run(8);
    chk("stall_cycles", stall_n, 4);
    chk("stall_cpu_rdata", cpu_rdata, 32'hA5A5_0003);

    // Lingering req through the done cycle gives exactly one access.
    q_c.push_back('{1'b0, 32'h20, 32'h0});
    drive_agents();
    busy_n = 0;
    order_q.delete();
    run(8);
    chk("linger_busy_cycles", busy_n, 2);
    chk("linger_done_count", order_q.size(), 1);

    // Reset while a store is in ACCESS.
    q_c.push_back('{1'b1, 32'h14, 32'hCAFE_F00D});
    drive_agents();
    run(1);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_mem_we",    {31'b0, mem_we},   32'h0);
    chk("rst_busy",      {31'b0, busy},     32'h0);
    chk("rst_cpu_done",  {31'b0, cpu_done}, 32'h0);
    chk("rst_ldr_done",  {31'b0, ldr_done}, 32'h0);
    chk("rst_mem_addr",  mem_addr,          32'h0);
    chk("rst_mem_wdata", mem_wdata,         32'h0);
    chk("rst_cpu_rdata", cpu_rdata,         32'h0);
    chk("rst_ldr_rdata", ldr_rdata,         32'h0);
    @(posedge clock);
    #1;
    drive_agents();
    run(4);
    q_c.push_back('{1'b0, 32'h14, 32'h0});
    drive_agents();
    run(5);
    chk("rst_reload_rdata", cpu_rdata, 32'hCAFE_F00D);

    // Randomized traffic with occasional resets.
    for (int it = 0; it < 2000; it++) begin
      if (!pend_c && q_c.size() == 0 && $urandom_range(0, 2) == 0) q_c.push_back(rand_req());
      if (!pend_l && q_l.size() == 0 && $urandom_range(0, 2) == 0) q_l.push_back(rand_req());
      reset = ($urandom_range(0, 199) == 0);
      drive_agents();
      run(1);
    end
    reset = 1'b0;
    run(8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
